alu_share_arbiter: RTL and testbench
====================================

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: FAIR_RR, default 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  32 each  requester 0 operands
- req0_op  in  alu_op_t  requester 0 operation
- req0_shamt  in  5  requester 0 shift amount
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_shamt  same widths, requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_data  out  32  registered ALU result
- rsp_zero  out  1  registered ALU zero flag
- alu_in1, alu_in2  out  32 each  operands to shared ALU
- alu_op_ctrl  out  alu_op_t  operation to shared ALU
- alu_shamt  out  5  shift amount to shared ALU
- alu_out  in  32  shared ALU result
- alu_zero  in  1  shared ALU zero flag
- busy  out  1  high whenever state is not IDLE

Function
REQ-004 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-005 Accept condition: reqN_valid && reqN_ready at a rising edge; reqN_ready SHALL be combinational, high only for the granted requester, and only in IDLE, or in RESP while rsp_ready=1.
REQ-006 Grant: one valid -> that one; both valid with FAIR_RR=1 -> the requester not granted last; FAIR_RR=0 -> requester 0.
REQ-007 On accept, the block SHALL register a, b, op, shamt and the requester id, update last_grant, and enter EXEC.
REQ-008 alu_in1/alu_in2/alu_op_ctrl/alu_shamt SHALL be driven only from the operand registers, never combinationally from request ports.
REQ-009 In EXEC, the block SHALL capture alu_out into rsp_data and alu_zero into rsp_zero at the closing edge, then enter RESP.
REQ-010 In RESP, rsp_valid=1; rsp_data, rsp_zero and rsp_id SHALL stay stable until rsp_ready=1.
REQ-011 RESP with rsp_ready=1: if a request is accepted in the same cycle -> EXEC (back-to-back); else -> IDLE.
REQ-012 Latency SHALL be exactly 2 cycles from the accept edge to rsp_valid high; peak throughput SHALL be one result per 2 cycles.
REQ-013 Requests not granted SHALL see reqN_ready=0 and SHALL NOT be dropped; the requester holds its inputs until accepted.
REQ-014 op SHALL be forwarded unmodified; any undefined encoding yields whatever the ALU returns (0, zero=1) with no error signalled.
REQ-015 Valid deassertion by a non-granted requester SHALL NOT disturb an operation in flight.
REQ-016 In IDLE, ALU drive registers SHALL hold their last values.

Reset
REQ-017 On rst=1, asynchronously: state=IDLE, all operand, result and id registers =0, last_grant=1 (requester 0 wins the first contention), rsp_valid=0, busy=0, both ready=0 while rst is asserted.
REQ-018 Reset during EXEC or RESP SHALL abort the operation; no rsp_valid SHALL appear after reset release without a new accept.

Verification
REQ-019 req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready pulse at cycle 0, rsp_valid at cycle 2, rsp_data=12, rsp_zero=0, rsp_id=0.
REQ-020 Both valid continuously with FAIR_RR=1, rsp_ready=1 -> grants alternate 0,1,0,1, with one result every 2 cycles.
REQ-021 req1 SUB a=9 b=9 with rsp_ready=0 for 4 cycles -> rsp_valid held high, rsp_data=0, rsp_zero=1, rsp_id=1 stable, req0_ready=0 throughout.
REQ-022 req0 SRA a=0x80000000 shamt=4 -> rsp_data=0xF8000000.
REQ-023 rst asserted while in EXEC -> rsp_valid=0 and busy=0 immediately, with no response after release.
REQ-024 FAIR_RR=0, both valid -> req0 always granted and req1 starves while req0 stays valid.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter time-sharing one external ALU; result 2 cycles after accept, 1 result / 2 cycles peak.
// Backpressure: a held response (rsp_ready=0) stalls both requesters; ungranted requests wait with ready low.
package alu_share_pkg;
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 4'h0;
    localparam alu_op_t ALU_SUB = 4'h1;
    localparam alu_op_t ALU_AND = 4'h2;
    localparam alu_op_t ALU_OR  = 4'h3;
    localparam alu_op_t ALU_XOR = 4'h4;
    localparam alu_op_t ALU_SLL = 4'h5;
    localparam alu_op_t ALU_SRL = 4'h6;
    localparam alu_op_t ALU_SRA = 4'h7;
    localparam alu_op_t ALU_SLT = 4'h8;
endpackage

module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int FAIR_RR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_a,
    input  logic [31:0]   req0_b,
    input  alu_op_t       req0_op,
    input  logic [4:0]    req0_shamt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_a,
    input  logic [31:0]   req1_b,
    input  alu_op_t       req1_op,
    input  logic [4:0]    req1_shamt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [31:0]   rsp_data,
    output logic          rsp_zero,
    output logic [31:0]   alu_in1,
    output logic [31:0]   alu_in2,
    output alu_op_t       alu_op_ctrl,
    output logic [4:0]    alu_shamt,
    input  logic [31:0]   alu_out,
    input  logic          alu_zero,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    alu_op_t       op_q, op_d;
    logic [4:0]    shamt_q, shamt_d;
    logic          id_q, id_d;
    logic          last_grant_q, last_grant_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_zero_q, rsp_zero_d;

    logic          can_accept;
    logic          pick1;
    logic          gnt0;
    logic          accept;

    always_comb begin
        can_accept = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
        // Requester 1 wins a contention only in round-robin mode and only if 0 went last
        pick1      = req1_valid && (!req0_valid || ((FAIR_RR != 0) && !last_grant_q));
        gnt0       = req0_valid && !pick1;
        req0_ready = can_accept && gnt0;
        req1_ready = can_accept && pick1;
        accept     = req0_ready || req1_ready;

        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        shamt_d      = shamt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;

        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                state_d    = RESP;
            end
            RESP: if (rsp_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d          = pick1 ? req1_a     : req0_a;
            b_d          = pick1 ? req1_b     : req0_b;
            op_d         = pick1 ? req1_op    : req0_op;
            shamt_d      = pick1 ? req1_shamt : req0_shamt;
            id_d         = pick1;
            last_grant_d = pick1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            shamt_q      <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            shamt_q      <= shamt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_in1     = a_q;
    assign alu_in2     = b_q;
    assign alu_op_ctrl = op_q;
    assign alu_shamt   = shamt_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: round-robin instance plus a fixed-priority instance on shared stimulus.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    alu_op_t req0_op, req1_op;
    logic [4:0] req0_shamt, req1_shamt;

    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, busy;
    logic [31:0] rsp_data, alu_in1, alu_in2, alu_out;
    alu_op_t alu_op_ctrl;
    logic [4:0] alu_shamt;
    logic alu_zero;

    logic fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_zero, fp_busy;
    logic [31:0] fp_rsp_data, fp_alu_in1, fp_alu_in2, fp_alu_out;
    alu_op_t fp_alu_op_ctrl;
    logic [4:0] fp_alu_shamt;
    logic fp_alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared ALU that sits outside the arbiter
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input alu_op_t op, input logic [4:0] sh);
        case (op)
            ALU_ADD: alu_f = a + b;
            ALU_SUB: alu_f = a - b;
            ALU_AND: alu_f = a & b;
            ALU_OR:  alu_f = a | b;
            ALU_XOR: alu_f = a ^ b;
            ALU_SLL: alu_f = a << sh;
            ALU_SRL: alu_f = a >> sh;
            ALU_SRA: alu_f = $signed(a) >>> sh;
            ALU_SLT: alu_f = {31'b0, $signed(a) < $signed(b)};
            default: alu_f = 32'h0;
        endcase
    endfunction

    assign alu_out     = alu_f(alu_in1, alu_in2, alu_op_ctrl, alu_shamt);
    assign alu_zero    = (alu_out == 32'h0);
    assign fp_alu_out  = alu_f(fp_alu_in1, fp_alu_in2, fp_alu_op_ctrl, fp_alu_shamt);
    assign fp_alu_zero = (fp_alu_out == 32'h0);

    alu_share_arbiter #(.FAIR_RR(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op_ctrl(alu_op_ctrl),
        .alu_shamt(alu_shamt), .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    alu_share_arbiter #(.FAIR_RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_shamt(req1_shamt),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data),
        .rsp_zero(fp_rsp_zero), .alu_in1(fp_alu_in1), .alu_in2(fp_alu_in2),
        .alu_op_ctrl(fp_alu_op_ctrl), .alu_shamt(fp_alu_shamt), .alu_out(fp_alu_out),
        .alu_zero(fp_alu_zero), .busy(fp_busy)
    );

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_a = 32'h11; req0_b = 32'h22; req0_op = ALU_ADD; req0_shamt = 5'd0;
        req1_a = 32'h33; req1_b = 32'h44; req1_op = ALU_SUB; req1_shamt = 5'd0;
        @(posedge clk); #1;
        checks++;
        if ({req1_ready, req0_ready, fp_req1_ready, fp_req0_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b exp 0000", {req1_ready, req0_ready, fp_req1_ready, fp_req0_ready});
        end
        checks++;
        if ({busy, rsp_valid, rsp_id, rsp_zero} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got busy/valid/id/zero=%b exp 0000", {busy, rsp_valid, rsp_id, rsp_zero});
        end
        checks++;
        if ({rsp_data, alu_in1, alu_in2} !== 96'h0 || alu_op_ctrl !== 4'h0 || alu_shamt !== 5'd0) begin
            errors++; $display("FAIL reset_regs: got data=%h in1=%h in2=%h op=%h sh=%0d exp all 0",
                               rsp_data, alu_in1, alu_in2, alu_op_ctrl, alu_shamt);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_add;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = ALU_ADD; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL add_cycle0: got ready0/ready1/rsp_valid=%b exp 100", {req0_ready, req1_ready, rsp_valid});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if ({busy, rsp_valid} !== 2'b10 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin
            errors++; $display("FAIL add_cycle1: got busy/valid=%b in1=%0d in2=%0d exp 10 5 7", {busy, rsp_valid}, alu_in1, alu_in2);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero} !== 3'b100 || rsp_data !== 32'd12) begin
            errors++; $display("FAIL add_cycle2: got valid/id/zero=%b data=%0d exp 100 12", {rsp_valid, rsp_id, rsp_zero}, rsp_data);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL add_idle: got busy/valid=%b exp 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_round_robin;
        logic e0, e1;
        int k;
        do_reset();
        req0_a = 32'd1;    req0_b = 32'd2;    req0_op = ALU_ADD;
        req1_a = 32'hF0;   req1_b = 32'hFF;   req1_op = ALU_XOR;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c == 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            e0 = (c % 2 == 0) && (c < 8) && ((c / 2) % 2 == 0);
            e1 = (c % 2 == 0) && (c < 8) && ((c / 2) % 2 == 1);
            checks++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                errors++; $display("FAIL rr_grant c%0d: got ready0/ready1=%b exp %b", c, {req0_ready, req1_ready}, {e0, e1});
            end
            if (c % 2 == 0 && c >= 2) begin
                k = c / 2 - 1;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== k[0] || rsp_data !== (k[0] ? 32'h0F : 32'd3)) begin
                    errors++; $display("FAIL rr_rsp c%0d: got valid=%b id=%b data=%h exp 1 %b %h",
                                       c, rsp_valid, rsp_id, rsp_data, k[0], (k[0] ? 32'h0F : 32'd3));
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL rr_novalid c%0d: got rsp_valid=%b exp 0", c, rsp_valid);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rr_end_idle: got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_stall;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = ALU_SUB; rsp_ready = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL stall_accept: got ready0/ready1=%b exp 01", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_ADD;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++; $display("FAIL stall_exec_ready0: got %b exp 0", req0_ready);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_zero, req0_ready} !== 4'b1110 || rsp_data !== 32'h0) begin
                errors++; $display("FAIL stall_hold c%0d: got valid/id/zero/ready0=%b data=%h exp 1110 0",
                                   c, {rsp_valid, rsp_id, rsp_zero, req0_ready}, rsp_data);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, req0_ready} !== 2'b11) begin
            errors++; $display("FAIL b2b_accept: got valid/ready0=%b exp 11", {rsp_valid, req0_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if ({busy, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL b2b_exec: got busy/valid=%b exp 10", {busy, rsp_valid});
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zero} !== 3'b100 || rsp_data !== 32'd2) begin
            errors++; $display("FAIL b2b_rsp: got valid/id/zero=%b data=%0d exp 100 2", {rsp_valid, rsp_id, rsp_zero}, rsp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ops;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        alu_op_t     top [4];
        logic [4:0]  tsh [4];
        logic [31:0] texp [4];
        logic        tz [4];
        ta[0] = 32'h8000_0000; tb[0] = 32'h0; top[0] = ALU_SRA; tsh[0] = 5'd4;  texp[0] = 32'hF800_0000; tz[0] = 1'b0;
        ta[1] = 32'h0000_1234; tb[1] = 32'h1; top[1] = 4'hF;    tsh[1] = 5'd0;  texp[1] = 32'h0;         tz[1] = 1'b1;
        ta[2] = 32'h0000_0001; tb[2] = 32'h0; top[2] = ALU_SLL; tsh[2] = 5'd31; texp[2] = 32'h8000_0000; tz[2] = 1'b0;
        ta[3] = 32'd3;         tb[3] = 32'd5; top[3] = ALU_SUB; tsh[3] = 5'd0;  texp[3] = 32'hFFFF_FFFE; tz[3] = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_a = ta[i]; req0_b = tb[i]; req0_op = top[i]; req0_shamt = tsh[i];
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                errors++; $display("FAIL op%0d_ready: got %b exp 1", i, req0_ready);
            end
            @(posedge clk); #1;
            req0_valid = 1'b0;
            req0_a = 32'hDEAD_BEEF; req0_op = ALU_ADD; req0_shamt = 5'd1;
            #1;
            checks++;
            if (alu_in1 !== ta[i] || alu_op_ctrl !== top[i] || alu_shamt !== tsh[i]) begin
                errors++; $display("FAIL op%0d_drive: got in1=%h op=%h sh=%0d exp %h %h %0d",
                                   i, alu_in1, alu_op_ctrl, alu_shamt, ta[i], top[i], tsh[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== texp[i] || rsp_zero !== tz[i]) begin
                errors++; $display("FAIL op%0d_result: got valid=%b data=%h zero=%b exp 1 %h %b",
                                   i, rsp_valid, rsp_data, rsp_zero, texp[i], tz[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || alu_in1 !== ta[i] || alu_op_ctrl !== top[i]) begin
                errors++; $display("FAIL op%0d_idle_hold: got busy=%b in1=%h op=%h exp 0 %h %h",
                                   i, busy, alu_in1, alu_op_ctrl, ta[i], top[i]);
            end
        end
    endtask

    task automatic test_reset_in_exec;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = ALU_ADD; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_exec_pre: got busy=%b exp 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00 || rsp_data !== 32'h0 || alu_in1 !== 32'h0) begin
            errors++; $display("FAIL rst_exec_abort: got valid/busy=%b data=%h in1=%h exp 00 0 0",
                               {rsp_valid, busy}, rsp_data, alu_in1);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                errors++; $display("FAIL rst_exec_after c%0d: got valid/busy=%b exp 00", c, {rsp_valid, busy});
            end
        end
    endtask

    task automatic test_fixed_priority;
        logic e0;
        do_reset();
        req0_a = 32'd1;  req0_b = 32'd2;  req0_op = ALU_ADD;
        req1_a = 32'hF0; req1_b = 32'hFF; req1_op = ALU_XOR;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            e0 = (c % 2 == 0);
            checks++;
            if ({fp_req0_ready, fp_req1_ready} !== {e0, 1'b0}) begin
                errors++; $display("FAIL fp_grant c%0d: got ready0/ready1=%b exp %b", c, {fp_req0_ready, fp_req1_ready}, {e0, 1'b0});
            end
            if (c >= 2 && e0) begin
                checks++;
                if (fp_rsp_valid !== 1'b1 || fp_rsp_id !== 1'b0 || fp_rsp_data !== 32'd3) begin
                    errors++; $display("FAIL fp_rsp c%0d: got valid=%b id=%b data=%h exp 1 0 3",
                                       c, fp_rsp_valid, fp_rsp_id, fp_rsp_data);
                end
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_stall();
        test_ops();
        test_reset_in_exec();
        test_fixed_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
